// File: rtl/microwave_sequencer_if.sv
// Signal bundle between the cook timer and the actuator sequencer.
// The timer side drives the i_* signals; the sequencer drives the o_* signals.
interface microwave_sequencer_if;
  logic       i_run;
  logic [3:0] i_state;
  logic       i_door_open;
  logic [1:0] i_power_lvl;
  logic       o_magnetron;
  logic       o_turntable;
  logic       o_lamp;
  logic       o_buzzer;
  logic       o_hold;
  logic       o_finish;
  logic [2:0] o_seq_state;

  modport master (
    output i_run, i_state, i_door_open, i_power_lvl,
    input  o_magnetron, o_turntable, o_lamp, o_buzzer, o_hold, o_finish, o_seq_state
  );

  modport slave (
    input  i_run, i_state, i_door_open, i_power_lvl,
    output o_magnetron, o_turntable, o_lamp, o_buzzer, o_hold, o_finish, o_seq_state
  );
endinterface

// File: rtl/microwave_sequencer.sv
// Microwave actuator sequencer: magnetron duty-cycling, door interlock,
// end-of-cook beeps and the finish acknowledge back to the cook timer.
module microwave_sequencer #(
  parameter int TICK_DIV       = 100_000,
  parameter int WINDOW_TICKS   = 4000,
  parameter int BEEP_ON_TICKS  = 500,
  parameter int BEEP_OFF_TICKS = 500,
  parameter int BEEP_COUNT     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  microwave_sequencer_if.slave bus
);
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int WIN_W  = $clog2(WINDOW_TICKS);
  localparam int BT_MAX = (BEEP_ON_TICKS > BEEP_OFF_TICKS) ? BEEP_ON_TICKS : BEEP_OFF_TICKS;
  localparam int BT_W   = $clog2(BT_MAX + 1);
  localparam int IDX_W  = $clog2(BEEP_COUNT + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_TICKS - 1);
  localparam logic [BT_W-1:0]  ON_LAST  = BT_W'(BEEP_ON_TICKS - 1);
  localparam logic [BT_W-1:0]  OFF_LAST = BT_W'(BEEP_OFF_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEEP_COUNT - 1);
  localparam logic [WIN_W:0]   Q1 = (WIN_W+1)'(WINDOW_TICKS / 4);
  localparam logic [WIN_W:0]   Q2 = (WIN_W+1)'(WINDOW_TICKS / 2);
  localparam logic [WIN_W:0]   Q3 = (WIN_W+1)'((WINDOW_TICKS / 4) * 3);
  localparam logic [WIN_W:0]   Q4 = (WIN_W+1)'(WINDOW_TICKS);

  typedef enum logic [2:0] {S_IDLE, S_HEAT, S_PAUSED, S_ALARM, S_DONE} state_t;

  state_t           state, nxt;
  logic [PRE_W-1:0] pre_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [1:0]       lvl;
  logic [WIN_W:0]   on_ticks;
  logic [BT_W-1:0]  beep_tk;
  logic [IDX_W-1:0] beep_idx;
  logic             beep_off;
  logic             tick, beep_end;
  logic             mag_reg, turn_reg, lamp_reg, buz_reg, hold_reg, fin_reg;
  logic [2:0]       seq_reg;

  assign tick     = (pre_cnt == PRE_LAST);
  assign beep_end = tick & beep_off & (beep_tk == OFF_LAST) & (beep_idx == IDX_LAST);

  always_comb begin
    on_ticks = Q4;
    case (lvl)
      2'd0:    on_ticks = Q1;
      2'd1:    on_ticks = Q2;
      2'd2:    on_ticks = Q3;
      default: on_ticks = Q4;
    endcase
  end

  // FINISH from the timer outranks run and door changes in every cooking state
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.i_state[3])                    nxt = S_ALARM;
        else if (bus.i_run && !bus.i_door_open) nxt = S_HEAT;
        else if (bus.i_run)                    nxt = S_PAUSED;
      end
      S_HEAT: begin
        if (bus.i_state[3])      nxt = S_ALARM;
        else if (!bus.i_run)     nxt = S_IDLE;
        else if (bus.i_door_open) nxt = S_PAUSED;
      end
      S_PAUSED: begin
        if (bus.i_state[3])       nxt = S_ALARM;
        else if (!bus.i_run)      nxt = S_IDLE;
        else if (!bus.i_door_open) nxt = S_HEAT;
      end
      S_ALARM: if (bus.i_door_open || beep_end) nxt = S_DONE;
      S_DONE:  if (!bus.i_state[3]) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pre_cnt  <= '0;
      win_cnt  <= '0;
      lvl      <= '0;
      beep_tk  <= '0;
      beep_idx <= '0;
      beep_off <= 1'b0;
      mag_reg  <= 1'b0;
      turn_reg <= 1'b0;
      lamp_reg <= 1'b0;
      buz_reg  <= 1'b0;
      hold_reg <= 1'b0;
      fin_reg  <= 1'b0;
      seq_reg  <= '0;
    end else begin
      state   <= nxt;
      pre_cnt <= (nxt != state || tick) ? '0 : pre_cnt + 1'b1;

      // Window restarts only on a fresh cook; a pause keeps the position
      if (state == S_IDLE && nxt == S_HEAT) begin
        win_cnt <= '0;
        lvl     <= bus.i_power_lvl;
      end else if (state == S_HEAT && tick) begin
        if (win_cnt == WIN_LAST) begin
          win_cnt <= '0;
          lvl     <= bus.i_power_lvl;
        end else begin
          win_cnt <= win_cnt + 1'b1;
        end
      end

      // Beep counters sit cleared outside ALARM so every entry starts on beep 0
      if (state != S_ALARM) begin
        beep_tk  <= '0;
        beep_idx <= '0;
        beep_off <= 1'b0;
      end else if (tick) begin
        if (!beep_off) begin
          if (beep_tk == ON_LAST) begin
            beep_tk  <= '0;
            beep_off <= 1'b1;
          end else begin
            beep_tk <= beep_tk + 1'b1;
          end
        end else if (beep_tk == OFF_LAST) begin
          beep_tk  <= '0;
          beep_off <= 1'b0;
          beep_idx <= beep_idx + 1'b1;
        end else begin
          beep_tk <= beep_tk + 1'b1;
        end
      end

      mag_reg  <= (state == S_HEAT) && ({1'b0, win_cnt} < on_ticks);
      turn_reg <= (nxt == S_HEAT);
      lamp_reg <= (nxt == S_HEAT) || (nxt == S_PAUSED);
      hold_reg <= (nxt == S_PAUSED);
      buz_reg  <= (state == S_ALARM) && (nxt == S_ALARM) && !beep_off;
      fin_reg  <= (state == S_ALARM) && (nxt == S_DONE);
      seq_reg  <= {nxt == S_PAUSED, nxt == S_HEAT, nxt == S_IDLE};
    end
  end

  // Interlock gate is combinational so the magnetron drops in the door-open cycle
  assign bus.o_magnetron = mag_reg & ~bus.i_door_open;
  assign bus.o_turntable = turn_reg;
  assign bus.o_lamp      = lamp_reg | bus.i_door_open;
  assign bus.o_buzzer    = buz_reg;
  assign bus.o_hold      = hold_reg;
  assign bus.o_finish    = fin_reg;
  assign bus.o_seq_state = seq_reg;
endmodule

// File: tb/tb_microwave_sequencer.sv
// Directed bench for microwave_sequencer with a fast tick:
// 4 clk per tick, 8-tick window, 2-tick beep phases, 3 beeps.
module tb_microwave_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cnt;
  int   fin_cnt;

  microwave_sequencer_if bus ();

  microwave_sequencer #(
    .TICK_DIV(4), .WINDOW_TICKS(8), .BEEP_ON_TICKS(2), .BEEP_OFF_TICKS(2), .BEEP_COUNT(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.i_run       = 1'b1;
    bus.i_state     = 4'b0100;
    bus.i_door_open = 1'b0;
    bus.i_power_lvl = 2'd1;

    // Reset held 3 cycles with run asserted
    cyc(3);
    check("rst_outs", {bus.o_magnetron, bus.o_turntable, bus.o_lamp, bus.o_buzzer,
                       bus.o_hold, bus.o_finish, bus.o_seq_state}, 32'h0);
    check("rst_mag", bus.o_magnetron, 0);
    rst_n = 1'b1;
    check("release_seq", bus.o_seq_state, 3'b000);

    // Cycle E: HEAT entered
    cyc(1);
    check("heat_seq", bus.o_seq_state, 3'b010);
    check("heat_turn", bus.o_turntable, 1);
    check("heat_mag_e", bus.o_magnetron, 0);
    cyc(1);
    check("lvl1_mag_on_first", bus.o_magnetron, 1);
    cyc(15);
    check("lvl1_mag_on_last", bus.o_magnetron, 1);
    cyc(1);
    check("lvl1_mag_off_first", bus.o_magnetron, 0);
    check("lvl1_turn", bus.o_turntable, 1);
    cyc(15);
    check("lvl1_mag_off_last", bus.o_magnetron, 0);
    cyc(1);
    check("lvl1_mag_on_again", bus.o_magnetron, 1);
    bus.i_power_lvl = 2'd3;
    cyc(17);
    check("lvl_change_deferred", bus.o_magnetron, 0);
    cyc(15);
    check("lvl3_first", bus.o_magnetron, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_magnetron) cnt++;
      cyc(1);
    end
    check("lvl3_continuous", cnt, 20);

    // Cycle E+88: win_cnt is 6 in the lvl=3 window
    cyc(3);
    bus.i_door_open = 1'b1;
    #1;
    check("door_mag_same_cycle", bus.o_magnetron, 0);
    check("door_lamp", bus.o_lamp, 1);
    cyc(1);
    check("paused_hold", bus.o_hold, 1);
    check("paused_seq", bus.o_seq_state, 3'b100);
    check("paused_turn", bus.o_turntable, 0);
    check("paused_lamp", bus.o_lamp, 1);
    cyc(9);
    check("paused_mag", bus.o_magnetron, 0);
    bus.i_power_lvl = 2'd1;
    bus.i_door_open = 1'b0;
    cyc(1);
    check("resume_seq", bus.o_seq_state, 3'b010);
    check("resume_hold", bus.o_hold, 0);
    check("resume_lamp", bus.o_lamp, 1);
    cyc(1);
    check("resume_mag", bus.o_magnetron, 1);
    cyc(7);
    check("resume_wrap_mag", bus.o_magnetron, 1);
    cyc(16);
    check("resume_win_on", bus.o_magnetron, 1);
    cyc(1);
    check("resume_win_off", bus.o_magnetron, 0);

    // Alarm: full beep sequence
    bus.i_state = 4'b1000;
    bus.i_run   = 1'b0;
    cyc(1);
    check("alarm_seq", bus.o_seq_state, 3'b000);
    check("alarm_buz_entry", bus.o_buzzer, 0);
    check("alarm_turn", bus.o_turntable, 0);
    cnt = 0;
    fin_cnt = 0;
    for (int k = 1; k <= 48; k++) begin
      cyc(1);
      if (bus.o_buzzer !== ((((k - 1) / 8) % 2) == 0)) cnt++;
      if (bus.o_finish !== (k == 48)) fin_cnt++;
    end
    check("alarm_buz_pattern_misses", cnt, 0);
    check("alarm_fin_timing_misses", fin_cnt, 0);
    check("alarm_fin_at_48", bus.o_finish, 1);
    cyc(1);
    check("done_fin_drop", bus.o_finish, 0);
    check("done_buz", bus.o_buzzer, 0);
    cyc(5);
    check("done_hold_seq", bus.o_seq_state, 3'b000);
    check("done_hold_fin", bus.o_finish, 0);
    bus.i_state = 4'b0001;
    cyc(1);
    check("done_to_idle", bus.o_seq_state, 3'b001);

    // Alarm abort on the 2nd beep
    bus.i_state = 4'b1000;
    cyc(1);
    check("abort_alarm_seq", bus.o_seq_state, 3'b000);
    cyc(19);
    check("abort_beep2_on", bus.o_buzzer, 1);
    bus.i_door_open = 1'b1;
    cyc(1);
    check("abort_buz_off", bus.o_buzzer, 0);
    check("abort_fin", bus.o_finish, 1);
    check("abort_lamp", bus.o_lamp, 1);
    cnt = 0;
    fin_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (bus.o_buzzer) cnt++;
      if (bus.o_finish) fin_cnt++;
    end
    check("abort_no_more_beeps", cnt, 0);
    check("abort_single_fin", fin_cnt, 0);
    bus.i_state     = 4'b0001;
    bus.i_door_open = 1'b0;
    cyc(1);
    check("abort_to_idle", bus.o_seq_state, 3'b001);

    // Priority: FINISH beats door/run while PAUSED
    bus.i_run       = 1'b1;
    bus.i_door_open = 1'b1;
    cyc(1);
    check("prio_paused", bus.o_seq_state, 3'b100);
    check("prio_paused_hold", bus.o_hold, 1);
    bus.i_state = 4'b1000;
    cyc(1);
    check("prio_alarm_seq", bus.o_seq_state, 3'b000);
    check("prio_alarm_hold", bus.o_hold, 0);
    bus.i_door_open = 1'b0;
    bus.i_run       = 1'b0;
    cyc(1);
    check("prio_alarm_buz", bus.o_buzzer, 1);
    check("prio_alarm_fin", bus.o_finish, 0);
    cyc(10);
    rst_n = 1'b0;
    cyc(1);
    check("midrst_outs", {bus.o_magnetron, bus.o_turntable, bus.o_lamp, bus.o_buzzer,
                          bus.o_hold, bus.o_finish, bus.o_seq_state}, 32'h0);
    rst_n       = 1'b1;
    bus.i_state = 4'b0001;
    cyc(1);
    check("midrst_idle", bus.o_seq_state, 3'b001);
    fin_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.o_finish) fin_cnt++;
      cyc(1);
    end
    check("midrst_no_fin", fin_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
